// File: rtl/oven_pkg.sv
// Shared oven types: FSM state codes, key step tables and target limits.
// Imported by the sequencer, display and heat-control blocks.
package oven_pkg;

  typedef enum logic [2:0] {
    ST_OFF      = 3'd0,
    ST_SET_TEMP = 3'd1,
    ST_SET_TIME = 3'd2,
    ST_PREHEAT  = 3'd3,
    ST_COOK     = 3'd4,
    ST_DONE     = 3'd5
  } state_e;

  localparam int OVEN_DEFAULT_TEMP = 300;
  localparam int OVEN_MIN_TEMP     = 65;
  localparam int OVEN_MAX_TEMP     = 500;
  localparam int OVEN_MAX_TIME     = 1800;
  localparam int OVEN_BUZZ_SEC     = 5;

  localparam logic [8:0] TEMP_STEP [5] = '{9'd5, 9'd10, 9'd25, 9'd50, 9'd100};
  localparam logic [8:0] TIME_STEP [5] = '{9'd5, 9'd10, 9'd30, 9'd60, 9'd300};

  // Anything other than exactly one switch up selects a zero step.
  function automatic logic [8:0] step_lookup(input logic [4:0] sw, input logic is_time);
    logic [8:0] step;
    step = '0;
    for (int i = 0; i < 5; i++) begin
      if (sw == 5'(1 << i)) step = is_time ? TIME_STEP[i] : TEMP_STEP[i];
    end
    return step;
  endfunction

  function automatic logic signed [13:0] sat14(input logic signed [13:0] v,
                                               input logic signed [13:0] lo,
                                               input logic signed [13:0] hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

endpackage

// File: rtl/oven_key_events.sv
// Key edge decoder: INC/DEC/CONFIRM single-cycle pulses from active-low key levels.
// Pulses are combinational off the current level and last cycle's history; no backpressure.
module oven_key_events (
  input  logic clk,
  input  logic rst,
  input  logic key0_i,
  input  logic key1_i,
  output logic inc_o,
  output logic dec_o,
  output logic confirm_o
);

  logic key0_q, key1_q;
  logic fall0, fall1;

  always_ff @(posedge clk) begin
    if (rst) begin
      key0_q <= 1'b1;
      key1_q <= 1'b1;
    end else begin
      key0_q <= key0_i;
      key1_q <= key1_i;
    end
  end

  assign fall0 = key0_q & ~key0_i;
  assign fall1 = key1_q & ~key1_i;

  // A fall with the other key down (already or simultaneously) is a chord, i.e. CONFIRM.
  assign inc_o     = fall1 & key0_i;
  assign dec_o     = fall0 & key1_i;
  assign confirm_o = (fall0 & ~key1_i) | (fall1 & ~key0_i);

endmodule

// File: rtl/oven_sequencer.sv
// Oven entry/preheat/cook/done controller; all outputs registered, state visible one cycle after its cause.
// No backpressure: key events and ticks are single-cycle pulses consumed on arrival.
module oven_sequencer
  import oven_pkg::*;
#(
  parameter int DEFAULT_TEMP = OVEN_DEFAULT_TEMP,
  parameter int MIN_TEMP     = OVEN_MIN_TEMP,
  parameter int MAX_TEMP     = OVEN_MAX_TEMP,
  parameter int MAX_TIME     = OVEN_MAX_TIME,
  parameter int BUZZ_SEC     = OVEN_BUZZ_SEC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pwr,
  input  logic        key0,
  input  logic        key1,
  input  logic [4:0]  sw,
  input  logic        tick_1hz,
  input  logic [9:0]  current_temp,
  output logic [9:0]  target_temp,
  output logic [12:0] target_time,
  output logic [12:0] remaining_time,
  output logic        heat_en,
  output logic [2:0]  state,
  output logic        done,
  output logic        buzzer
);

  state_e      state_q, state_d;
  logic [9:0]  temp_q, temp_d;
  logic [12:0] time_q, time_d;
  logic [12:0] rem_q, rem_d;
  logic        heat_q, heat_d;
  logic        done_q, done_d;
  logic        buzz_q, buzz_d;
  logic [7:0]  buzz_cnt_q, buzz_cnt_d;

  logic inc, dec, confirm;

  oven_key_events u_keys (
    .clk      (clk),
    .rst      (rst),
    .key0_i   (key0),
    .key1_i   (key1),
    .inc_o    (inc),
    .dec_o    (dec),
    .confirm_o(confirm)
  );

  logic signed [13:0] temp_step, time_step, temp_sum, time_sum, temp_sat, time_sat;

  always_comb begin
    temp_step = $signed({5'd0, step_lookup(sw, 1'b0)});
    time_step = $signed({5'd0, step_lookup(sw, 1'b1)});
    temp_sum  = $signed({4'd0, temp_q}) + (dec ? -temp_step : temp_step);
    time_sum  = $signed({1'b0, time_q}) + (dec ? -time_step : time_step);
    temp_sat  = sat14(temp_sum, 14'(MIN_TEMP), 14'(MAX_TEMP));
    time_sat  = sat14(time_sum, 14'sd0, 14'(MAX_TIME));
  end

  always_comb begin
    state_d    = state_q;
    temp_d     = temp_q;
    time_d     = time_q;
    rem_d      = rem_q;
    buzz_d     = buzz_q;
    buzz_cnt_d = buzz_cnt_q;

    if (!pwr) begin
      state_d    = ST_OFF;
      rem_d      = '0;
      buzz_d     = 1'b0;
      buzz_cnt_d = '0;
    end else begin
      unique case (state_q)
        ST_OFF: begin
          state_d = ST_SET_TEMP;
          temp_d  = 10'(DEFAULT_TEMP);
          time_d  = '0;
        end
        ST_SET_TEMP: begin
          if (confirm)         state_d = ST_SET_TIME;
          else if (inc || dec) temp_d  = temp_sat[9:0];
        end
        ST_SET_TIME: begin
          if (confirm) begin
            if (time_q != '0) state_d = ST_PREHEAT;
          end else if (inc || dec) begin
            time_d = time_sat[12:0];
          end
        end
        ST_PREHEAT: begin
          if (confirm) begin
            state_d = ST_SET_TEMP;
          end else if (current_temp >= temp_q) begin
            state_d = ST_COOK;
            rem_d   = time_q;
          end
        end
        ST_COOK: begin
          if (confirm) begin
            state_d = ST_SET_TEMP;
            rem_d   = '0;
          end else if (tick_1hz) begin
            if (rem_q <= 13'd1) begin
              rem_d      = '0;
              state_d    = ST_DONE;
              buzz_d     = 1'b1;
              buzz_cnt_d = '0;
            end else begin
              rem_d = rem_q - 13'd1;
            end
          end
        end
        ST_DONE: begin
          if (confirm) begin
            state_d = ST_SET_TEMP;
            buzz_d  = 1'b0;
          end else if (tick_1hz && buzz_q) begin
            // Silence on the BUZZ_SEC-th tick after entering DONE.
            buzz_cnt_d = buzz_cnt_q + 8'd1;
            if (buzz_cnt_q + 8'd1 >= 8'(BUZZ_SEC)) buzz_d = 1'b0;
          end
        end
        default: state_d = ST_OFF;
      endcase
    end

    heat_d = (state_d == ST_PREHEAT) || (state_d == ST_COOK);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_OFF;
      temp_q     <= 10'(DEFAULT_TEMP);
      time_q     <= '0;
      rem_q      <= '0;
      heat_q     <= 1'b0;
      done_q     <= 1'b0;
      buzz_q     <= 1'b0;
      buzz_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      temp_q     <= temp_d;
      time_q     <= time_d;
      rem_q      <= rem_d;
      heat_q     <= heat_d;
      done_q     <= done_d;
      buzz_q     <= buzz_d;
      buzz_cnt_q <= buzz_cnt_d;
    end
  end

  assign state          = state_q;
  assign target_temp    = temp_q;
  assign target_time    = time_q;
  assign remaining_time = rem_q;
  assign heat_en        = heat_q;
  assign done           = done_q;
  assign buzzer         = buzz_q;

endmodule
